// File: rtl/bus_pkg.sv
// Shared definitions for the serialized external memory link arbiter.
// Holds the FSM state encoding, default frame geometry, byte width and
// the uio direction codes used on ext_oe.
package bus_pkg;

  localparam int BYTE_W       = 8;
  localparam int NBYTES_DEF   = 4;
  localparam int TURN_CYC_DEF = 1;

  localparam logic [BYTE_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [BYTE_W-1:0] OE_INPUT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    TURN,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   req        : per-port request
//   enable     : arbitration allowed (link idle)
//   last_grant : index of the port that won the most recent tie
//   grant      : one-hot winner, zero when disabled or nothing requested
//   valid      : a grant is being issued this cycle
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie: the port that did not win last time goes first.
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    valid = |grant;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Shares one 8-bit serialized memory link between instruction fetch (port 0)
// and load/store (port 1). A granted request is sent as NBYTES little-endian
// address beats (write data rides alongside on ext_dout); reads then turn
// the bus around for TURN_CYC cycles and collect NBYTES data beats.
//   clk, rst_n          : clock, async active-low reset
//   req, we             : per-port request / write enable (held until ack)
//   addr0/1, wdata0/1   : per-port address and write data
//   ack                 : one-cycle completion pulse for the granted port
//   rdata               : last completed read word, updated with ack
//   ext_addr, ext_dout  : address / write-data byte lanes
//   ext_oe              : uio direction (all drive or all input)
//   ext_din             : read-data byte lane
//   ext_sync            : marks the first address beat of a frame
//   busy                : link not idle
module serial_bus_arbiter
  import bus_pkg::*;
#(
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int NBYTES   = NBYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [BYTE_W*NBYTES-1:0] addr0,
  input  logic [BYTE_W*NBYTES-1:0] addr1,
  input  logic [BYTE_W*NBYTES-1:0] wdata0,
  input  logic [BYTE_W*NBYTES-1:0] wdata1,
  output logic [1:0]               ack,
  output logic [BYTE_W*NBYTES-1:0] rdata,
  output logic [BYTE_W-1:0]        ext_addr,
  output logic [BYTE_W-1:0]        ext_dout,
  output logic [BYTE_W-1:0]        ext_oe,
  input  logic [BYTE_W-1:0]        ext_din,
  output logic                     ext_sync,
  output logic                     busy
);

  localparam logic [2:0] LAST_BEAT = 3'(NBYTES - 1);
  localparam logic [2:0] LAST_TURN = 3'(TURN_CYC - 1);

  typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

  state_t            state, state_n;
  logic [2:0]        cnt;
  logic [1:0]        gnt;
  logic [1:0]        arb_grant;
  logic              arb_valid;
  logic              last_grant;
  logic              lat_we;
  word_t             lat_addr, lat_wdata, rbuf, rbuf_n;
  logic [BYTE_W-1:0] addr_byte, wdata_byte;

  rr_arb2 u_arb (
    .req        (req),
    .enable     (state == IDLE),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Beat k selects byte k; the same selection steers ext_din into the
  // read buffer so the final beat can be folded straight into rdata.
  always_comb begin
    addr_byte  = '0;
    wdata_byte = '0;
    rbuf_n     = rbuf;
    for (int k = 0; k < NBYTES; k++) begin
      if (cnt == 3'(k)) begin
        addr_byte  = lat_addr[k];
        wdata_byte = lat_wdata[k];
        rbuf_n[k]  = ext_din;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (arb_valid) state_n = ADDR;
      ADDR: if (cnt == LAST_BEAT) state_n = lat_we ? DONE : TURN;
      TURN: if (cnt == LAST_TURN) state_n = DATA;
      DATA: if (cnt == LAST_BEAT) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pins decode straight from registered state so an async reset clears
  // them without waiting for a clock edge.
  always_comb begin
    ext_addr = '0;
    ext_dout = '0;
    ext_oe   = OE_INPUT;
    ext_sync = 1'b0;
    ack      = 2'b00;
    case (state)
      ADDR: begin
        ext_addr = addr_byte;
        ext_sync = (cnt == 3'd0);
        if (lat_we) begin
          ext_dout = wdata_byte;
          ext_oe   = OE_DRIVE;
        end
      end
      DONE:    ack = gnt;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 2'b00;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rbuf       <= '0;
      rdata      <= '0;
    end else begin
      state <= state_n;
      // Restart the beat count on every state entry; IDLE just parks at 0.
      if (state_n != state || state == IDLE) cnt <= '0;
      else                                   cnt <= cnt + 3'd1;

      if (state == IDLE && arb_valid) begin
        gnt       <= arb_grant;
        lat_we    <= arb_grant[0] ? we[0]  : we[1];
        lat_addr  <= arb_grant[0] ? addr0  : addr1;
        lat_wdata <= arb_grant[0] ? wdata0 : wdata1;
        if (&req) last_grant <= arb_grant[1];
      end

      if (state == DATA) begin
        rbuf <= rbuf_n;
        if (cnt == LAST_BEAT) rdata <= rbuf_n;
      end
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench: each stimulus pushes one expected pin/ack/rdata tuple
// per busy cycle; a negedge monitor pops and compares while the selected
// DUT is busy and checks quiet pins while it is idle. Instance a uses the
// default turnaround, instance b uses TURN_CYC=3.
module tb_serial_bus_arbiter;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_a, req_b, we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [7:0]  ext_din;
  logic [1:0]  ack_a, ack_b;
  logic [31:0] rdata_a, rdata_b;
  logic [7:0]  ea_a, ea_b, ed_a, ed_b, oe_a, oe_b;
  logic        sync_a, sync_b, busy_a, busy_b;

  serial_bus_arbiter u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_a), .rdata(rdata_a), .ext_addr(ea_a), .ext_dout(ed_a),
    .ext_oe(oe_a), .ext_din(ext_din), .ext_sync(sync_a), .busy(busy_a)
  );

  serial_bus_arbiter #(.TURN_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_b), .rdata(rdata_b), .ext_addr(ea_b), .ext_dout(ed_b),
    .ext_oe(oe_b), .ext_din(ext_din), .ext_sync(sync_b), .busy(busy_b)
  );

  logic        sel = 1'b0;
  logic        m_busy;
  logic [26:0] m_pins;
  logic [31:0] m_rdata;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_rdata = sel ? rdata_b : rdata_a;
  assign m_pins  = sel ? {ack_b, sync_b, oe_b, ea_b, ed_b}
                       : {ack_a, sync_a, oe_a, ea_a, ed_a};

  typedef struct {
    int          cyc;
    logic [26:0] pins;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  din_sched[int];
  logic [31:0] model_rdata = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-data lane follows a per-cycle schedule; other cycles carry junk.
  always @(posedge clk) begin
    #1;
    ext_din = din_sched.exists(cyc) ? din_sched[cyc] : 8'h5A;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [26:0] pk(input logic [1:0] a, input logic s,
                                     input logic [7:0] oe, input logic [7:0] ad,
                                     input logic [7:0] d);
    return {a, s, oe, ad, d};
  endfunction

  task automatic put(input exp_t e, inout int n, input int keep);
    if (keep < 0 || n < keep) exp_q.push_back(e);
    n++;
  endtask

  // Queue the expected busy cycles of one frame whose request is sampled in
  // cycle c0. keep>=0 truncates the frame (reset-abort case). nx returns the
  // first idle cycle after DONE.
  task automatic push_frame(input int c0, input int port, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] din, input int turn,
                            input int keep, output int nx);
    int c, n;
    logic [31:0] nxt;
    exp_t e;
    c = c0 + 1;
    n = 0;
    nxt = wr ? model_rdata : din;
    for (int k = 0; k < 4; k++) begin
      e.cyc   = c;
      e.rdata = model_rdata;
      e.pins  = pk(2'b00, k == 0, wr ? 8'hFF : 8'h00, 8'(a >> (8 * k)),
                   wr ? 8'(wd >> (8 * k)) : 8'h00);
      put(e, n, keep);
      c++;
    end
    if (!wr) begin
      for (int k = 0; k < turn; k++) begin
        e.cyc = c; e.rdata = model_rdata; e.pins = '0;
        put(e, n, keep);
        c++;
      end
      for (int k = 0; k < 4; k++) begin
        din_sched[c] = 8'(din >> (8 * k));
        e.cyc = c; e.rdata = model_rdata; e.pins = '0;
        put(e, n, keep);
        c++;
      end
    end
    e.cyc   = c;
    e.rdata = nxt;
    e.pins  = pk(port == 1 ? 2'b10 : 2'b01, 1'b0, 8'h00, 8'h00, 8'h00);
    put(e, n, keep);
    if (keep < 0) model_rdata = nxt;
    nx = c + 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy", 32'(m_busy), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("frame_cycle", cyc, e.cyc);
        chk("pins", 32'(m_pins), 32'(e.pins));
        chk("rdata", m_rdata, e.rdata);
      end
    end else begin
      chk("idle_pins", 32'(m_pins), 32'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_busy", 32'(m_busy), 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int c0, nx, saved;
    req_a = 2'b00; req_b = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ext_din = 8'h00;

    // Reset state
    step(); step();
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_rdata", rdata_a, 32'd0);
    chk("reset_pins", {5'd0, ack_a, sync_a, oe_a, ea_a, ed_a}, 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Single read, port 0
    c0 = cyc;
    req_a = 2'b01; we = 2'b00; addr0 = 32'h1234_5678;
    push_frame(c0, 0, 1'b0, addr0, '0, 32'hDDCC_BBAA, 1, -1, nx);
    wait_to(nx);
    req_a = 2'b00;
    step(); step();

    // Single write, port 1
    c0 = cyc;
    req_a = 2'b10; we = 2'b10; addr1 = 32'h0000_00F0; wdata1 = 32'hCAFE_BABE;
    push_frame(c0, 1, 1'b1, addr1, wdata1, '0, 1, -1, nx);
    wait_to(nx);
    req_a = 2'b00; we = 2'b00;
    step(); step();

    // Contention: both reads held, expect 0,1,0 with one idle cycle between
    c0 = cyc;
    req_a = 2'b11; addr0 = 32'hA3A2_A1A0; addr1 = 32'hB3B2_B1B0;
    push_frame(c0, 0, 1'b0, addr0, '0, 32'h1122_3344, 1, -1, nx);
    push_frame(nx, 1, 1'b0, addr1, '0, 32'h5566_7788, 1, -1, nx);
    push_frame(nx, 0, 1'b0, addr0, '0, 32'h99AA_BBCC, 1, -1, nx);
    wait_to(nx);
    req_a = 2'b00;
    step(); step();

    // Withdrawal: req0 dropped in cycle 2, frame still completes
    c0 = cyc;
    req_a = 2'b01; addr0 = 32'h0000_0004;
    push_frame(c0, 0, 1'b0, addr0, '0, 32'h0F1E_2D3C, 1, -1, nx);
    wait_to(c0 + 2);
    req_a = 2'b00;
    wait_to(nx);
    step();

    // Turnaround 3 on instance b
    saved = model_rdata;
    model_rdata = '0;
    sel = 1'b1;
    step();
    c0 = cyc;
    req_b = 2'b01; addr0 = 32'hDEAD_BEEF;
    push_frame(c0, 0, 1'b0, addr0, '0, 32'h8765_4321, 3, -1, nx);
    wait_to(nx);
    req_b = 2'b00;
    step();
    sel = 1'b0;
    model_rdata = saved;
    step();

    // Reset in cycle 3 of a write: pins drop at once, no ack
    c0 = cyc;
    req_a = 2'b10; we = 2'b10; addr1 = 32'h0000_0100; wdata1 = 32'h0102_0304;
    push_frame(c0, 1, 1'b1, addr1, wdata1, '0, 1, 2, nx);
    wait_to(c0 + 3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_pins", {5'd0, ack_a, sync_a, oe_a, ea_a, ed_a}, 32'd0);
    chk("abort_rdata", rdata_a, 32'd0);
    model_rdata = '0;
    req_a = 2'b11; we = 2'b00; addr0 = 32'h0000_0A00; addr1 = 32'h0000_0B00;
    step(); step();
    rst_n = 1'b1;
    c0 = cyc;
    push_frame(c0, 0, 1'b0, addr0, '0, 32'h0BAD_F00D, 1, -1, nx);
    wait_to(nx);
    req_a = 2'b00;
    step(); step(); step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares the single 8-bit serialized external memory link between two CPU-side requesters: port 0 (instruction fetch) and port 1 (load/store).
- Grants one requester at a time, round-robin.
- Serializes its 32-bit address and write data out over byte lanes, and for reads collects 32-bit read data back.
- Sits between the CPU core and the top-level pin wrapper. Its ext_* ports map directly to uo_out/uio_out/uio_oe/uio_in.

Parameters:
- TURN_CYC, 1, bus turnaround cycles between the last address beat and the first read beat (1..7).
- NBYTES, 4, bytes per address/data word (word width = 8*NBYTES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-port request; must be held until that port's ack
- we  in  2  per-port write enable (1 = write, 0 = read)
- addr0, addr1  in  32  per-port address
- wdata0, wdata1  in  32  per-port write data
- ack  out  2  one-cycle completion pulse per port
- rdata  out  32  read data, valid with ack, held until next read completes
- ext_addr  out  8  address byte lane (to uo_out)
- ext_dout  out  8  write-data byte lane (to uio_out)
- ext_oe  out  8  uio direction: 8'hFF drive, 8'h00 input
- ext_din  in  8  read-data byte lane (from uio_in)
- ext_sync  out  1  high only on the first address beat of a frame
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: asynchronous assertion forces state IDLE and clears all outputs and rdata to 0. last_grant resets to 1, so port 0 wins the first tie.
- Reset mid-frame aborts the frame: no ack is issued and the pins go to zero immediately.
- Byte order is little-endian and non-overlapping: beat k carries bits [8k+7:8k], for k = 0..NBYTES-1.
- Arbitration happens only in IDLE:
  - If exactly one req is high, that port is granted.
  - If both are high, the port other than last_grant is granted, and last_grant is updated.
  - The grant, plus latched copies of that port's addr/wdata/we, is taken at the accepting edge.
  - Requester inputs are ignored after acceptance.
- The FSM states below are registered. Cycle 0 is the IDLE cycle in which req is sampled.
  - IDLE: ext_oe=0, ext_addr=0, ext_dout=0.
  - ADDR, cycles 1..NBYTES: ext_addr = addr byte k. ext_sync=1 in cycle 1 only.
    - Write: ext_dout = wdata byte k, ext_oe=8'hFF.
    - Read: ext_dout=0, ext_oe=0.
    - After the last beat: write -> DONE, read -> TURN.
  - TURN, TURN_CYC cycles: ext_oe=0, ext_addr=0, ext_dout=0.
  - DATA, NBYTES cycles: ext_din is captured into rdata byte k at the end of each cycle. ext_oe=0.
  - DONE, 1 cycle: ack[grant]=1 and the rdata update becomes visible. Next state is IDLE.
- Latency with defaults:
  - Write: ack in cycle 5.
  - Read: TURN in cycle 5, DATA in cycles 6..9, ack in cycle 10.
  - Back-to-back: the next request is sampled in the IDLE cycle after DONE (minimum 1 idle cycle between frames).
- A write does not modify rdata.
- If req drops mid-frame, the frame still completes and ack still pulses. The requester must ignore the ack.
- A req held after its own ack counts as a new request.
- Beat counter is 3 bits and reloads to 0 on every state entry. It never wraps mid-phase.

Decomposition:
- Shared package (bus_pkg):
  - state enum {IDLE, ADDR, TURN, DATA, DONE}
  - NBYTES and TURN_CYC defaults
  - BYTE_W=8
  - OE_DRIVE=8'hFF, OE_INPUT=8'h00
- Sub-module rr_arb2: 2-input round-robin arbiter. Inputs req[1:0], enable (IDLE), last_grant. Outputs a one-hot grant and a valid.

Test Plan:
- Single read, port 0: req=01, we=0, addr0=32'h1234_5678. Expect:
  - ext_addr 78,56,34,12 in cycles 1..4, ext_sync in cycle 1, ext_oe=00 throughout.
  - Drive ext_din AA,BB,CC,DD in cycles 6..9 -> ack=01 in cycle 10, rdata=32'hDDCC_BBAA.
- Single write, port 1: we=1, addr1=32'h0000_00F0, wdata1=32'hCAFE_BABE. Expect:
  - ext_dout BE,BA,FE,CA with ext_oe=FF in cycles 1..4.
  - ack=10 in cycle 5. rdata unchanged.
- Contention: both req held continuously, both reads. Expect grants alternating port0, port1, port0.
  - Each ack pulses exactly once per frame.
  - 1 idle cycle between frames.
- Turnaround parameter: TURN_CYC=3 read. Expect DATA in cycles 8..11 and ack in cycle 12. ext_oe=00 in cycles 5..7.
- Reset mid-frame: assert rst_n low in cycle 3 of a write. Expect:
  - ext_oe, ext_addr, ext_dout, busy all 0 immediately, with no ack.
  - After release, a port-0/port-1 tie grants port 0.
- Request withdrawal: drop req0 in cycle 2 of a read. Expect the frame to complete and ack[0] to pulse in cycle 10.
